framing_mdio_ctrl: RTL



---
 rtl/framing_mdio_pkg.sv | 34 +++
 rtl/framing_mdio_clkgen.sv | 44 ++++
 rtl/framing_mdio_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/framing_mdio_pkg.sv
// framing_mdio_pkg: shared types and Clause 22 frame constants for the
// framing block's MDIO master.
package framing_mdio_pkg;

   // Controller phases, in frame order
   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      DONE
   } mdio_state_t;

   localparam logic [1:0] MDIO_ST        = 2'b01;
   localparam logic [1:0] MDIO_OP_WR     = 2'b01;
   localparam logic [1:0] MDIO_OP_RD     = 2'b10;
   localparam logic [1:0] MDIO_TA_WR     = 2'b10;
   localparam int         MDIO_HDR_BITS  = 14;
   localparam int         MDIO_DATA_BITS = 16;

   // Post-preamble frame image, MSB transmitted first. For reads the TA and
   // DATA fields are never driven, so they are filled with ones.
   function automatic logic [31:0] mdio_frame(input logic        write,
                                              input logic [4:0]  phy_addr,
                                              input logic [4:0]  reg_addr,
                                              input logic [15:0] wdata);
      logic [31:0] f;
      if (write) f = {MDIO_ST, MDIO_OP_WR, phy_addr, reg_addr, MDIO_TA_WR, wdata};
      else       f = {MDIO_ST, MDIO_OP_RD, phy_addr, reg_addr, 2'b11, 16'hFFFF};
      return f;
   endfunction

endpackage

// File: rtl/framing_mdio_clkgen.sv
// framing_mdio_clkgen: MDC generator. One bit period is 2*CLK_DIV cycles,
// MDC low for the first half and high for the second. The phase counter
// sits at zero whenever the generator is disabled, so every frame starts
// with a full low half-period.
module framing_mdio_clkgen #(
   parameter int CLK_DIV = 20
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic mdc,
   output logic fall_stb,
   output logic rise_end_stb
);

   localparam int            PERIOD = 2 * CLK_DIV;
   localparam int            CW     = $clog2(PERIOD);
   localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
   localparam logic [CW-1:0] HALF   = CW'(CLK_DIV);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Next phase: wrap at the end of the bit, park at zero when disabled
   always_comb begin
      cnt_nxt = '0;
      if (en && (cnt != LAST)) cnt_nxt = cnt + CW'(1);
   end

   // Phase counter and MDC, registered from the same next value so MDC is glitch-free
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         mdc <= (cnt_nxt >= HALF);
      end
   end

   assign fall_stb     = en && (cnt == '0);
   assign rise_end_stb = en && (cnt == LAST);

endmodule

// File: rtl/framing_mdio_ctrl.sv
// framing_mdio_ctrl: IEEE 802.3 Clause 22 MDIO master for the framing
// block's management register. One request at a time; the frame is
// serialised on MDC/MDIO and reads return data with a one-cycle pulse.
// Optional build macro FRAMING_MDIO_PRESUP_EN adds req_no_pre, which skips
// the preamble for that request.
module framing_mdio_ctrl
   import framing_mdio_pkg::*;
#(
   parameter int CLK_DIV = 20,
   parameter int PRE_LEN = 32
) (
   input  logic        msoc_clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_phy_addr,
   input  logic [4:0]  req_reg_addr,
   input  logic [15:0] req_wdata,
`ifdef FRAMING_MDIO_PRESUP_EN
   input  logic        req_no_pre,
`endif
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        o_edutmdc,
   input  logic        i_edutmdio,
   output logic        o_edutmdio,
   output logic        oe_edutmdio
);

   mdio_state_t state;
   logic [5:0]  bit_cnt;
   logic [31:0] tx_sr;
   logic [15:0] rx_sr;
   logic        wr_q;
   logic        no_pre_q;
   logic        ta_err;
   logic        mdio_s1;
   logic        mdio_s2;
   logic        clk_en;
   logic        rise_end_stb;
   logic        unused_fall_stb;
   logic        no_pre;
   logic [31:0] frame_w;

`ifdef FRAMING_MDIO_PRESUP_EN
   assign no_pre = req_no_pre;
`else
   assign no_pre = 1'b0;
`endif

   assign frame_w = mdio_frame(req_write, req_phy_addr, req_reg_addr, req_wdata);
   assign clk_en  = (state != IDLE) && (state != DONE);

   // The next bit's pin values are loaded on the preceding rise_end edge (or
   // on acceptance), so they are already stable when the bit-start strobe
   // fires; that strobe therefore has no consumer here.
   framing_mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk          (msoc_clk),
      .rstn         (rstn),
      .en           (clk_en),
      .mdc          (o_edutmdc),
      .fall_stb     (unused_fall_stb),
      .rise_end_stb (rise_end_stb)
   );

   // Two-flop synchroniser for the PHY-driven MDIO input (idles high like the bus)
   always_ff @(posedge msoc_clk) begin
      if (!rstn) begin
         mdio_s1 <= 1'b1;
         mdio_s2 <= 1'b1;
      end else begin
         mdio_s1 <= i_edutmdio;
         mdio_s2 <= mdio_s1;
      end
   end

   // Frame sequencer: state, bit counter, shift registers and all registered outputs
   always_ff @(posedge msoc_clk) begin
      if (!rstn) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         wr_q        <= 1'b0;
         no_pre_q    <= 1'b0;
         ta_err      <= 1'b0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         o_edutmdio  <= 1'b1;
         oe_edutmdio <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q        <= req_write;
                  no_pre_q    <= no_pre;
                  tx_sr       <= frame_w;
                  req_ready   <= 1'b0;
                  busy        <= 1'b1;
                  oe_edutmdio <= 1'b1;
                  if (no_pre) begin
                     state      <= HDR;
                     bit_cnt    <= 6'(MDIO_HDR_BITS - 1);
                     o_edutmdio <= frame_w[31];
                  end else begin
                     state      <= PRE;
                     bit_cnt    <= 6'(PRE_LEN - 1);
                     o_edutmdio <= 1'b1;
                  end
               end
            end

            PRE: begin
               if (rise_end_stb) begin
                  if (bit_cnt == '0) begin
                     state      <= HDR;
                     bit_cnt    <= 6'(MDIO_HDR_BITS - 1);
                     o_edutmdio <= tx_sr[31];
                  end else begin
                     bit_cnt    <= bit_cnt - 6'd1;
                     o_edutmdio <= 1'b1;
                  end
               end
            end

            HDR: begin
               if (rise_end_stb) begin
                  tx_sr <= {tx_sr[30:0], 1'b0};
                  if (bit_cnt == '0) begin
                     state       <= TA;
                     bit_cnt     <= 6'd1;
                     oe_edutmdio <= wr_q;
                     o_edutmdio  <= wr_q ? tx_sr[30] : 1'b1;
                  end else begin
                     bit_cnt    <= bit_cnt - 6'd1;
                     o_edutmdio <= tx_sr[30];
                  end
               end
            end

            TA: begin
               if (rise_end_stb) begin
                  tx_sr      <= {tx_sr[30:0], 1'b0};
                  o_edutmdio <= wr_q ? tx_sr[30] : 1'b1;
                  if (bit_cnt == '0) begin
                     // a PHY that answers pulls the second TA bit low
                     ta_err  <= mdio_s2;
                     state   <= DATA;
                     bit_cnt <= 6'(MDIO_DATA_BITS - 1);
                  end else begin
                     bit_cnt <= bit_cnt - 6'd1;
                  end
               end
            end

            DATA: begin
               if (rise_end_stb) begin
                  tx_sr <= {tx_sr[30:0], 1'b0};
                  rx_sr <= {rx_sr[14:0], mdio_s2};
                  if (bit_cnt == '0) begin
                     state       <= DONE;
                     bit_cnt     <= '0;
                     o_edutmdio  <= 1'b1;
                     oe_edutmdio <= 1'b0;
                     rsp_valid   <= 1'b1;
                     // the final sample goes straight into the response so it lines up with rsp_valid
                     if (!wr_q) begin
                        rsp_rdata <= {rx_sr[14:0], mdio_s2};
                        rsp_err   <= ta_err;
                     end else begin
                        rsp_err   <= 1'b0;
                     end
                  end else begin
                     bit_cnt    <= bit_cnt - 6'd1;
                     o_edutmdio <= wr_q ? tx_sr[30] : 1'b1;
                  end
               end
            end

            DONE: begin
               state     <= IDLE;
               bit_cnt   <= '0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end

            default: begin
               state     <= IDLE;
               bit_cnt   <= '0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
